// File: rtl/etai_eval_pkg.sv
// Shared types and widths for the ETAI error evaluator.
//   state_t    : evaluator FSM states
//   ed_width() : error-distance width for an N-bit adder with a K-bit precise part
//   DEF_*      : default parameter values
package etai_eval_pkg;

    localparam int unsigned DEF_N     = 16;
    localparam int unsigned DEF_K     = 12;
    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_ACC_W = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The ETAI error is bounded by the approximate part plus one bit.
    function automatic int unsigned ed_width(input int unsigned n, input int unsigned k);
        return n - k + 1;
    endfunction

endpackage

// File: rtl/etai_approx_model.sv
// Combinational ETAI approximate adder producing an N+1 bit sum.
//   x, y : N-bit operands
//   sum  : {carry, precise upper K bits, approximate lower N-K bits}
// Upper part is an exact add with carry-in 0. Lower part is scanned MSB to LSB:
// from the first position where both operands are 1, that bit and every bit
// below it are forced to 1; bits above it are x^y.
module etai_approx_model #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 12
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N:0]   sum
);

    localparam int unsigned L = N - K;

    logic [K:0]   hi_sum;
    logic [L-1:0] lo_sum;
    logic         stop;

    assign hi_sum = (K+1)'(x[N-1:L]) + (K+1)'(y[N-1:L]);

    // Lower-part scan from the top approximate bit down to bit 0.
    always_comb begin
        stop   = 1'b0;
        lo_sum = '0;
        for (int i = int'(L) - 1; i >= 0; i--) begin
            if (x[i] && y[i]) begin
                stop = 1'b1;
            end
            lo_sum[i] = stop ? 1'b1 : (x[i] ^ y[i]);
        end
    end

    assign sum = {hi_sum, lo_sum};

endmodule

// File: rtl/etai_error_evaluator.sv
// Streaming ETAI accuracy evaluator. Accepts operand pairs over valid/ready,
// compares the ETAI sum against the exact sum and accumulates error metrics
// over a programmed number of samples. Two-stage pipeline from accept to
// accumulator update.
//   clk, rst       : clock, synchronous active-high reset
//   start          : begins a run (only from IDLE or DONE); latches num_samples
//   in_valid/ready : operand handshake; x, y operands
//   busy, done     : run in progress / run complete (held until next start)
//   sample_count   : samples retired into the accumulators
//   err_count      : samples whose approximate sum differs from the exact sum
//   sum_abs_err    : saturating sum of |ED|
//   max_err        : largest |ED| seen
//   sum_sq_err     : saturating sum of ED*ED (only when ETAI_SQERR_EN is defined)
module etai_error_evaluator
    import etai_eval_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned K     = DEF_K,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_samples,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                x,
    input  logic [N-1:0]                y,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            sample_count,
    output logic [CNT_W-1:0]            err_count,
    output logic [ACC_W-1:0]            sum_abs_err,
`ifdef ETAI_SQERR_EN
    output logic [2*ed_width(N,K)+CNT_W-1:0] sum_sq_err,
`endif
    output logic [ed_width(N,K)-1:0]    max_err
);

    localparam int unsigned EDW = ed_width(N, K);
`ifdef ETAI_SQERR_EN
    localparam int unsigned SQW = 2*EDW + CNT_W;
`endif

    state_t           state;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] accepted_next;
    logic             fire;

    logic [N:0]       approx_c;
    logic [N:0]       exact_c;
    logic [EDW-1:0]   ed_c;

    logic             s1_valid;
    logic [N:0]       s1_approx;
    logic [N:0]       s1_exact;
    logic             s2_valid;
    logic [EDW-1:0]   s2_ed;
    logic             s2_err;
    logic [ACC_W:0]   sum_ext;
`ifdef ETAI_SQERR_EN
    logic [2*EDW-1:0] s2_sq;
    logic [SQW:0]     sq_ext;
`endif

    assign fire          = in_valid && in_ready;
    assign accepted_next = accepted + CNT_W'(fire);

    etai_approx_model #(.N(N), .K(K)) u_approx (
        .x   (x),
        .y   (y),
        .sum (approx_c)
    );

    assign exact_c = (N+1)'(x) + (N+1)'(y);

    // ED fits in EDW bits by the ETAI error bound.
    assign ed_c = EDW'((s1_approx >= s1_exact) ? (s1_approx - s1_exact)
                                               : (s1_exact - s1_approx));

    // One extra bit on each accumulator exposes the overflow for saturation.
    assign sum_ext = {1'b0, sum_abs_err} + (ACC_W+1)'(s2_ed);
`ifdef ETAI_SQERR_EN
    assign sq_ext  = {1'b0, sum_sq_err} + (SQW+1)'(s2_sq);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            num_q        <= '0;
            accepted     <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            s1_valid     <= 1'b0;
            s1_approx    <= '0;
            s1_exact     <= '0;
            s2_valid     <= 1'b0;
            s2_ed        <= '0;
            s2_err       <= 1'b0;
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_err  <= '0;
            max_err      <= '0;
`ifdef ETAI_SQERR_EN
            s2_sq        <= '0;
            sum_sq_err   <= '0;
`endif
        end else begin
            // S1: register both sums on transfer.
            s1_valid <= fire;
            if (fire) begin
                s1_approx <= approx_c;
                s1_exact  <= exact_c;
            end

            // S2: error distance and error flag.
            s2_valid <= s1_valid;
            s2_ed    <= ed_c;
            s2_err   <= (s1_approx != s1_exact);
`ifdef ETAI_SQERR_EN
            s2_sq    <= (2*EDW)'(ed_c) * (2*EDW)'(ed_c);
`endif

            // Accumulate on S2 valid; counters saturate.
            if (s2_valid) begin
                sample_count <= sample_count + CNT_W'(1);
                if (s2_err && (err_count != '1)) begin
                    err_count <= err_count + CNT_W'(1);
                end
                sum_abs_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
                if (s2_ed > max_err) begin
                    max_err <= s2_ed;
                end
`ifdef ETAI_SQERR_EN
                sum_sq_err <= sq_ext[SQW] ? '1 : sq_ext[SQW-1:0];
`endif
            end

            // Run control; start only reaches here with an empty pipeline.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        num_q        <= num_samples;
                        accepted     <= '0;
                        in_ready     <= (num_samples != '0);
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        sample_count <= '0;
                        err_count    <= '0;
                        sum_abs_err  <= '0;
                        max_err      <= '0;
`ifdef ETAI_SQERR_EN
                        sum_sq_err   <= '0;
`endif
                    end
                end
                RUN: begin
                    accepted <= accepted_next;
                    if (accepted_next >= num_q) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (sample_count == num_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_etai_error_evaluator.sv
// Directed self-checking bench for etai_error_evaluator (N=16, K=12).
module tb_etai_error_evaluator;

    localparam int unsigned N     = 16;
    localparam int unsigned K     = 12;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned ACC_W = 48;
    localparam int unsigned EDW   = N - K + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     x;
    logic [N-1:0]     y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_abs_err;
    logic [EDW-1:0]   max_err;
`ifdef ETAI_SQERR_EN
    logic [2*EDW+CNT_W-1:0] sum_sq_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference pairs; hand-computed ED per pair: 1, 0, 15, 0.
    logic [N-1:0] px [4] = '{16'h000F, 16'h0001, 16'h000F, 16'h1230};
    logic [N-1:0] py [4] = '{16'h0001, 16'h0002, 16'h000F, 16'h0450};

    etai_error_evaluator #(.N(N), .K(K), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .y            (y),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .sum_abs_err  (sum_abs_err),
`ifdef ETAI_SQERR_EN
        .sum_sq_err   (sum_sq_err),
`endif
        .max_err      (max_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_metrics(input string pfx, input int sc, input int ec,
                                 input int sae, input int mx);
        check({pfx, "_sample_count"}, 64'(sample_count), 64'(sc));
        check({pfx, "_err_count"},    64'(err_count),    64'(ec));
        check({pfx, "_sum_abs_err"},  64'(sum_abs_err),  64'(sae));
        check({pfx, "_max_err"},      64'(max_err),      64'(mx));
    endtask

    task automatic start_run(input int n);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        @(negedge clk);
        start       = 1'b0;
    endtask

    // Hold a pair valid until accepted (bounded).
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        int i = 0;
        in_valid = 1'b1;
        x        = a;
        y        = b;
        while (!in_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (i >= 20) check({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_samples = '0;
        in_valid    = 1'b0;
        x           = '0;
        y           = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check_metrics("rst", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back run of 4 pairs
        start_run(4);
        check("a_busy", 64'(busy), 64'd1);
        check("a_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) send(px[i], py[i], "a");
        in_valid = 1'b0;
        check("a_drain_ready", 64'(in_ready), 64'd0);
        check("a_drain_done", 64'(done), 64'd0);
        wait_done(10, "a");
        check("a_busy_end", 64'(busy), 64'd0);
        check_metrics("a", 4, 2, 16, 15);
`ifdef ETAI_SQERR_EN
        check("a_sum_sq_err", 64'(sum_sq_err), 64'd226);
`endif

        // Same pairs with valid toggling; extra pairs after the 4th must be ignored
        start_run(4);
        check_metrics("b_clear", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            send(px[i], py[i], "b");
            in_valid = 1'b0;
            if (i < 3) @(negedge clk);
        end
        check("b_ready_drop", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        x        = 16'h000F;
        y        = 16'h000F;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_done(10, "b");
        check_metrics("b", 4, 2, 16, 15);

        // Zero-sample run
        start_run(0);
        check("z_in_ready", 64'(in_ready), 64'd0);
        wait_done(3, "z");
        check_metrics("z", 0, 0, 0, 0);

        // Start pulsed mid-run is ignored
        start_run(4);
        send(px[0], py[0], "m");
        send(px[1], py[1], "m");
        start       = 1'b1;
        num_samples = CNT_W'(1);
        send(px[2], py[2], "m");
        start       = 1'b0;
        send(px[3], py[3], "m");
        in_valid = 1'b0;
        check("m_busy", 64'(busy), 64'd1);
        wait_done(10, "m");
        check_metrics("m", 4, 2, 16, 15);
`ifdef ETAI_SQERR_EN
        check("m_sum_sq_err", 64'(sum_sq_err), 64'd226);
`endif

        // New start after done clears metrics; (0008,0008) -> ED 1
        start_run(1);
        check("n_done_clear", 64'(done), 64'd0);
        check_metrics("n_clear", 0, 0, 0, 0);
        send(16'h0008, 16'h0008, "n");
        in_valid = 1'b0;
        wait_done(10, "n");
        check_metrics("n", 1, 1, 1, 1);

        // Reset during DRAIN discards everything including in-flight samples
        start_run(4);
        for (int i = 0; i < 4; i++) send(px[i], py[i], "r");
        in_valid = 1'b0;
        check("r_in_drain", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r_busy", 64'(busy), 64'd0);
        check("r_done", 64'(done), 64'd0);
        check("r_in_ready", 64'(in_ready), 64'd0);
        check_metrics("r", 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        check("r_done_later", 64'(done), 64'd0);
        check_metrics("r_later", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
